// File: rtl/instr_fetcher.sv
// Byte-serial instruction fetch stage between the iq tail PC and the memory controller.
// Define ICACHE_EN to add a direct-mapped instruction cache that bypasses mc on a hit.
module instr_fetcher #(
  parameter int AddrWidth       = 32,
  parameter int ICacheIndexBits = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 is_exception_from_rob,
  input  logic                 is_empty_from_iq,
  input  logic [AddrWidth-1:0] pc_from_iq,
  input  logic                 is_grant_from_mc,
  input  logic [7:0]           byte_from_mc,
  input  logic                 is_byte_valid_from_mc,
  output logic                 is_request_to_mc,
  output logic [AddrWidth-1:0] addr_to_mc,
  output logic [31:0]          instr_to_iq,
  output logic                 is_finish_to_iq,
  output logic                 is_instr_to_iq,
  output logic                 is_stall_to_iq
);

  typedef enum logic [2:0] {IDLE, REQ, RECV, DONE, DRAIN} state_e;

  state_e                 state_q, state_d;
  logic                   req_q, req_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic [31:0]            instr_q, instr_d;
  logic                   finish_q, finish_d;
  logic                   stall_q, stall_d;
  logic [1:0]             byte_cnt_q, byte_cnt_d;
  logic [2:0]             drain_cnt_q, drain_cnt_d;
  logic [31:0]            word_q, word_d;
  logic [2:0]             bytes_rcvd;
  logic                   cache_hit;
  logic [31:0]            cache_data;

`ifdef ICACHE_EN
  localparam int Entries = 1 << ICacheIndexBits;
  localparam int TagW    = AddrWidth - ICacheIndexBits - 2;

  logic [Entries-1:0]         valid_q;
  logic [TagW-1:0]            tag_mem  [Entries];
  logic [31:0]                data_mem [Entries];
  logic [ICacheIndexBits-1:0] rd_idx, wr_idx;

  assign rd_idx     = pc_from_iq[ICacheIndexBits+1:2];
  // addr_q holds the word address of the fetch currently completing in DONE
  assign wr_idx     = addr_q[ICacheIndexBits+1:2];
  assign cache_hit  = valid_q[rd_idx] && (tag_mem[rd_idx] == pc_from_iq[AddrWidth-1:ICacheIndexBits+2]);
  assign cache_data = data_mem[rd_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                valid_q         <= '0;
    else if (state_q == DONE) valid_q[wr_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (state_q == DONE) begin
      tag_mem[wr_idx]  <= addr_q[AddrWidth-1:ICacheIndexBits+2];
      data_mem[wr_idx] <= instr_q;
    end
  end
`else
  assign cache_hit  = 1'b0;
  assign cache_data = '0;
`endif

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    addr_d      = addr_q;
    instr_d     = instr_q;
    finish_d    = 1'b0;
    stall_d     = 1'b1;
    byte_cnt_d  = byte_cnt_q;
    drain_cnt_d = drain_cnt_q;
    word_d      = word_q;
    bytes_rcvd  = {1'b0, byte_cnt_q} + {2'b00, is_byte_valid_from_mc};
    case (state_q)
      IDLE: begin
        if (!is_exception_from_rob && !is_empty_from_iq) begin
          addr_d = pc_from_iq & ~AddrWidth'(3);
          if (cache_hit) begin
            state_d  = DONE;
            finish_d = 1'b1;
            stall_d  = 1'b0;
            instr_d  = cache_data;
          end else begin
            state_d = REQ;
            req_d   = 1'b1;
          end
        end
      end
      REQ: begin
        if (is_exception_from_rob) begin
          // a grant in the same cycle means four bytes are already on their way
          req_d       = 1'b0;
          state_d     = is_grant_from_mc ? DRAIN : IDLE;
          drain_cnt_d = 3'd4;
        end else if (is_grant_from_mc) begin
          req_d      = 1'b0;
          byte_cnt_d = 2'd0;
          state_d    = RECV;
        end
      end
      RECV: begin
        if (is_byte_valid_from_mc) begin
          word_d[8*byte_cnt_q +: 8] = byte_from_mc;
          byte_cnt_d                = byte_cnt_q + 2'd1;
        end
        if (is_exception_from_rob) begin
          drain_cnt_d = 3'd4 - bytes_rcvd;
          state_d     = (bytes_rcvd == 3'd4) ? IDLE : DRAIN;
        end else if (is_byte_valid_from_mc && byte_cnt_q == 2'd3) begin
          state_d  = DONE;
          finish_d = 1'b1;
          stall_d  = 1'b0;
          instr_d  = word_d;
        end
      end
      DONE: state_d = IDLE;
      DRAIN: begin
        // a flush while draining changes nothing: the outstanding bytes still arrive
        if (is_byte_valid_from_mc && drain_cnt_q != 3'd0) drain_cnt_d = drain_cnt_q - 3'd1;
        if (drain_cnt_q == 3'd0 || (is_byte_valid_from_mc && drain_cnt_q == 3'd1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      addr_q      <= '0;
      instr_q     <= '0;
      finish_q    <= 1'b0;
      stall_q     <= 1'b1;
      byte_cnt_q  <= 2'd0;
      drain_cnt_q <= 3'd0;
      word_q      <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      instr_q     <= instr_d;
      finish_q    <= finish_d;
      stall_q     <= stall_d;
      byte_cnt_q  <= byte_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      word_q      <= word_d;
    end
  end

  assign is_request_to_mc = req_q;
  assign addr_to_mc       = addr_q;
  assign instr_to_iq      = instr_q;
  assign is_finish_to_iq  = finish_q;
  assign is_instr_to_iq   = finish_q;
  assign is_stall_to_iq   = stall_q;

endmodule

// File: tb/tb_instr_fetcher.sv
// Directed self-checking bench for instr_fetcher; inputs change and outputs are sampled 1ns after each rising edge.
module tb_instr_fetcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        is_exception_from_rob;
  logic        is_empty_from_iq;
  logic [31:0] pc_from_iq;
  logic        is_grant_from_mc;
  logic [7:0]  byte_from_mc;
  logic        is_byte_valid_from_mc;
  logic        is_request_to_mc;
  logic [31:0] addr_to_mc;
  logic [31:0] instr_to_iq;
  logic        is_finish_to_iq;
  logic        is_instr_to_iq;
  logic        is_stall_to_iq;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  instr_fetcher #(.AddrWidth(32), .ICacheIndexBits(6)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .is_exception_from_rob (is_exception_from_rob),
    .is_empty_from_iq      (is_empty_from_iq),
    .pc_from_iq            (pc_from_iq),
    .is_grant_from_mc      (is_grant_from_mc),
    .byte_from_mc          (byte_from_mc),
    .is_byte_valid_from_mc (is_byte_valid_from_mc),
    .is_request_to_mc      (is_request_to_mc),
    .addr_to_mc            (addr_to_mc),
    .instr_to_iq           (instr_to_iq),
    .is_finish_to_iq       (is_finish_to_iq),
    .is_instr_to_iq        (is_instr_to_iq),
    .is_stall_to_iq        (is_stall_to_iq)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    is_byte_valid_from_mc = 1'b1;
    byte_from_mc          = b;
    step();
    is_byte_valid_from_mc = 1'b0;
  endtask

  // Accept pc, take the grant one cycle later, then stream four contiguous bytes.
  task automatic fetch_word(input string tag, input logic [31:0] pc, input logic [31:0] word);
    is_empty_from_iq = 1'b0;
    pc_from_iq       = pc;
    step();
    chk({tag, "_req"}, {31'd0, is_request_to_mc}, 32'd1);
    chk({tag, "_addr"}, addr_to_mc, pc & 32'hFFFF_FFFC);
    is_empty_from_iq = 1'b1;
    is_grant_from_mc = 1'b1;
    step();
    is_grant_from_mc = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(word[8*i +: 8]);
    chk({tag, "_finish"}, {31'd0, is_finish_to_iq}, 32'd1);
    chk({tag, "_instr"}, instr_to_iq, word);
    step();
    chk({tag, "_finish_drop"}, {31'd0, is_finish_to_iq}, 32'd0);
    $display("txn %s pc=0x%08h instr=0x%08h", tag, pc, word);
  endtask

  initial begin
    rst = 1'b0;
    is_exception_from_rob = 1'b0;
    is_empty_from_iq      = 1'b1;
    pc_from_iq            = 32'h0;
    is_grant_from_mc      = 1'b0;
    byte_from_mc          = 8'h0;
    is_byte_valid_from_mc = 1'b0;
    step();
    step();
    chk("rst_req",    {31'd0, is_request_to_mc}, 32'd0);
    chk("rst_stall",  {31'd0, is_stall_to_iq},   32'd1);
    chk("rst_finish", {31'd0, is_finish_to_iq},  32'd0);
    rst = 1'b1;

    // Reset asserted mid-RECV
    is_empty_from_iq = 1'b0;
    pc_from_iq       = 32'h0000_0104;
    step();
    chk("pre_rst_req", {31'd0, is_request_to_mc}, 32'd1);
    is_empty_from_iq = 1'b1;
    is_grant_from_mc = 1'b1;
    step();
    is_grant_from_mc = 1'b0;
    send_byte(8'hAA);
    send_byte(8'hBB);
    rst = 1'b0;
    #1;
    chk("midrst_req",    {31'd0, is_request_to_mc}, 32'd0);
    chk("midrst_addr",   addr_to_mc,                32'd0);
    chk("midrst_instr",  instr_to_iq,               32'd0);
    chk("midrst_finish", {31'd0, is_finish_to_iq},  32'd0);
    chk("midrst_isinst", {31'd0, is_instr_to_iq},   32'd0);
    chk("midrst_stall",  {31'd0, is_stall_to_iq},   32'd1);
    step();
    rst              = 1'b1;
    pc_from_iq       = 32'h0;
    is_empty_from_iq = 1'b0;
    step();
    chk("postrst_req",  {31'd0, is_request_to_mc}, 32'd1);
    chk("postrst_addr", addr_to_mc,                32'd0);
    $display("txn reset_mid_recv request=%0d addr=0x%08h", is_request_to_mc, addr_to_mc);
    rst = 1'b0;
    is_empty_from_iq = 1'b1;
    #1;
    rst = 1'b1;
    step();

    // Basic fetch
    is_empty_from_iq = 1'b0;
    pc_from_iq       = 32'h0000_0104;
    step();
    chk("basic_req",   {31'd0, is_request_to_mc}, 32'd1);
    chk("basic_addr",  addr_to_mc,                32'h0000_0104);
    chk("basic_stall_req", {31'd0, is_stall_to_iq}, 32'd1);
    is_empty_from_iq = 1'b1;
    is_grant_from_mc = 1'b1;
    step();
    is_grant_from_mc = 1'b0;
    chk("basic_req_clr", {31'd0, is_request_to_mc}, 32'd0);
    send_byte(8'h93);
    send_byte(8'h00);
    send_byte(8'h10);
    chk("basic_no_early_finish", {31'd0, is_finish_to_iq}, 32'd0);
    send_byte(8'h00);
    chk("basic_finish", {31'd0, is_finish_to_iq}, 32'd1);
    chk("basic_isinst", {31'd0, is_instr_to_iq},  32'd1);
    chk("basic_stall",  {31'd0, is_stall_to_iq},  32'd0);
    chk("basic_instr",  instr_to_iq,              32'h0010_0093);
    step();
    chk("basic_finish_drop", {31'd0, is_finish_to_iq}, 32'd0);
    chk("basic_isinst_drop", {31'd0, is_instr_to_iq},  32'd0);
    chk("basic_stall_back",  {31'd0, is_stall_to_iq},  32'd1);
    $display("txn basic pc=0x00000104 instr=0x%08h", instr_to_iq);

    // Backpressure: iq full for five cycles
    is_empty_from_iq = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pc_from_iq = 32'h0000_0280 + 32'(4 * i);
      step();
      chk("bp_req",   {31'd0, is_request_to_mc}, 32'd0);
      chk("bp_stall", {31'd0, is_stall_to_iq},   32'd1);
    end
    pc_from_iq       = 32'h0000_0302;
    is_empty_from_iq = 1'b0;
    step();
    chk("bp_release_req",  {31'd0, is_request_to_mc}, 32'd1);
    chk("bp_release_addr", addr_to_mc,                32'h0000_0300);
    $display("txn backpressure release addr=0x%08h", addr_to_mc);

    // Grant delayed three cycles; a stray byte before the grant is ignored
    is_empty_from_iq = 1'b1;
    pc_from_iq       = 32'h0000_0998;
    for (int i = 0; i < 3; i++) begin
      is_byte_valid_from_mc = (i == 1);
      byte_from_mc          = 8'h55;
      step();
      chk("gd_req_held",  {31'd0, is_request_to_mc}, 32'd1);
      chk("gd_addr_held", addr_to_mc,                32'h0000_0300);
    end
    is_byte_valid_from_mc = 1'b0;
    is_grant_from_mc      = 1'b1;
    step();
    is_grant_from_mc = 1'b0;
    chk("gd_req_clr", {31'd0, is_request_to_mc}, 32'd0);
    send_byte(8'hEF);
    step();
    send_byte(8'hBE);
    step();
    step();
    chk("gd_no_finish_gap", {31'd0, is_finish_to_iq}, 32'd0);
    send_byte(8'hAD);
    send_byte(8'hDE);
    chk("gd_finish", {31'd0, is_finish_to_iq}, 32'd1);
    chk("gd_instr",  instr_to_iq,              32'hDEAD_BEEF);
    step();
    chk("gd_single_finish", {31'd0, is_finish_to_iq}, 32'd0);
    $display("txn gaps pc=0x00000300 instr=0x%08h", instr_to_iq);

    // Flush after two bytes, then drain the remaining two
    is_empty_from_iq = 1'b0;
    pc_from_iq       = 32'h0000_0400;
    step();
    is_empty_from_iq = 1'b1;
    is_grant_from_mc = 1'b1;
    step();
    is_grant_from_mc = 1'b0;
    send_byte(8'h11);
    send_byte(8'h22);
    is_exception_from_rob = 1'b1;
    step();
    is_exception_from_rob = 1'b0;
    chk("fl_no_finish", {31'd0, is_finish_to_iq},  32'd0);
    chk("fl_no_req",    {31'd0, is_request_to_mc}, 32'd0);
    is_empty_from_iq = 1'b0;
    pc_from_iq       = 32'h0000_0200;
    send_byte(8'h33);
    chk("fl_drain1_no_req", {31'd0, is_request_to_mc}, 32'd0);
    send_byte(8'h44);
    chk("fl_drain2_no_req", {31'd0, is_request_to_mc}, 32'd0);
    chk("fl_drain_no_finish", {31'd0, is_finish_to_iq}, 32'd0);
    step();
    chk("fl_restart_req",  {31'd0, is_request_to_mc}, 32'd1);
    chk("fl_restart_addr", addr_to_mc,                32'h0000_0200);
    is_empty_from_iq = 1'b1;
    is_grant_from_mc = 1'b1;
    step();
    is_grant_from_mc = 1'b0;
    send_byte(8'h13);
    send_byte(8'h05);
    send_byte(8'h00);
    send_byte(8'h00);
    chk("fl_next_finish", {31'd0, is_finish_to_iq}, 32'd1);
    chk("fl_next_instr",  instr_to_iq,              32'h0000_0513);
    step();
    $display("txn flush_then_refetch pc=0x00000200 instr=0x%08h", instr_to_iq);

    // Re-fetch 0x104: a cache hit when the cache is built in, otherwise a normal mc fetch
`ifdef ICACHE_EN
    is_empty_from_iq = 1'b0;
    pc_from_iq       = 32'h0000_0104;
    step();
    is_empty_from_iq = 1'b1;
    chk("hit_finish", {31'd0, is_finish_to_iq},  32'd1);
    chk("hit_instr",  instr_to_iq,               32'h0010_0093);
    chk("hit_no_req", {31'd0, is_request_to_mc}, 32'd0);
    chk("hit_stall",  {31'd0, is_stall_to_iq},   32'd0);
    step();
    chk("hit_no_req_after", {31'd0, is_request_to_mc}, 32'd0);
    chk("hit_finish_drop",  {31'd0, is_finish_to_iq},  32'd0);
    $display("txn cache_hit pc=0x00000104");
`else
    fetch_word("refetch", 32'h0000_0104, 32'h0010_0093);
`endif

    // Conflicting address (same index) evicts 0x104, so 0x104 then misses
    fetch_word("conflict", 32'h0000_0204, 32'hAABB_CCDD);
    fetch_word("evicted",  32'h0000_0104, 32'h0010_0093);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
